// File: rtl/bus_op_sequencer.sv
// Bus operation sequencer for the LLC model: issues one MESI bus operation, gathers
// the snoop answer from the other caches and returns shared/timeout status upstream.
module bus_op_sequencer #(
    parameter int ADDR_W        = 32,
    parameter int SNOOP_TIMEOUT = 15,
    parameter int STAT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              bus_valid,
    output logic [2:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_grant,
    input  logic              snoop_valid,
    input  logic [1:0]        snoop_result,
    input  logic              wb_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_shared,
    output logic              rsp_timeout,
    output logic              protocol_err,
    output logic [STAT_W-1:0] cnt_hitm,
    output logic [STAT_W-1:0] cnt_timeout,
    output logic [2:0]        state_dbg
);

    // Handshakes: a transfer happens in any cycle where valid and ready are both high;
    // the side holding valid keeps its payload stable until that cycle.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_SNOOP   = 3'd2,
        S_WAIT_WB = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_INV   = 3'd3;
    localparam logic [2:0] OP_RWIM  = 3'd4;
    localparam int         TMR_W    = (SNOOP_TIMEOUT < 2) ? 1 : $clog2(SNOOP_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SNOOP_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                shared_q, shared_d;
    logic                timeout_q, timeout_d;
    logic                perr_q, perr_d;
    logic [STAT_W-1:0]   hitm_q, hitm_d;
    logic [STAT_W-1:0]   tocnt_q, tocnt_d;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        tmr_d     = tmr_q;
        shared_d  = shared_q;
        timeout_d = timeout_q;
        perr_d    = 1'b0;
        hitm_d    = hitm_q;
        tocnt_d   = tocnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_op inside {OP_READ, OP_WRITE, OP_INV, OP_RWIM}) begin
                        op_d    = req_op;
                        addr_d  = req_addr;
                        state_d = S_ISSUE;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (bus_grant) begin
                    tmr_d     = '0;
                    shared_d  = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = (op_q == OP_WRITE) ? S_RESP : S_SNOOP;
                end
            end
            S_SNOOP: begin
                tmr_d = tmr_q + 1'b1;
                if (snoop_valid) begin
                    state_d = S_RESP;
                    case (snoop_result)
                        2'd0: shared_d = 1'b0;
                        // Every HITM result is counted, including the illegal one on INVALIDATE.
                        2'd2: begin
                            hitm_d = (&hitm_q) ? hitm_q : hitm_q + 1'b1;
                            if (op_q == OP_INV) begin
                                perr_d   = 1'b1;
                                shared_d = 1'b0;
                            end else begin
                                state_d = S_WAIT_WB;
                            end
                        end
                        default: shared_d = (op_q == OP_READ);
                    endcase
                end else if (tmr_q == TMR_LAST) begin
                    state_d   = S_RESP;
                    shared_d  = 1'b0;
                    timeout_d = 1'b1;
                    tocnt_d   = (&tocnt_q) ? tocnt_q : tocnt_q + 1'b1;
                end
            end
            S_WAIT_WB: begin
                if (wb_done) begin
                    shared_d = (op_q == OP_READ);
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    shared_d  = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            tmr_q     <= '0;
            shared_q  <= 1'b0;
            timeout_q <= 1'b0;
            perr_q    <= 1'b0;
            hitm_q    <= '0;
            tocnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            tmr_q     <= tmr_d;
            shared_q  <= shared_d;
            timeout_q <= timeout_d;
            perr_q    <= perr_d;
            hitm_q    <= hitm_d;
            tocnt_q   <= tocnt_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign bus_valid    = (state_q == S_ISSUE);
    assign rsp_valid    = (state_q == S_RESP);
    assign bus_op       = op_q;
    assign bus_addr     = addr_q;
    assign rsp_shared   = shared_q;
    assign rsp_timeout  = timeout_q;
    assign protocol_err = perr_q;
    assign cnt_hitm     = hitm_q;
    assign cnt_timeout  = tocnt_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_bus_op_sequencer.sv
// Randomized bench for bus_op_sequencer: a transaction-level model predicts every
// output each cycle, plus literal latency/result checks from the directed cases.
module tb_bus_op_sequencer;

    localparam int AW = 32;
    localparam int TO = 15;
    localparam int SW = 3;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_INV   = 3'd3;
    localparam logic [2:0] OP_RWIM  = 3'd4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [2:0]    req_op;
    logic [AW-1:0] req_addr;
    logic          bus_valid;
    logic [2:0]    bus_op;
    logic [AW-1:0] bus_addr;
    logic          bus_grant, snoop_valid, wb_done;
    logic [1:0]    snoop_result;
    logic          rsp_valid, rsp_ready, rsp_shared, rsp_timeout, protocol_err;
    logic [SW-1:0] cnt_hitm, cnt_timeout;
    logic [2:0]    state_dbg;

    always #5 clk = ~clk;

    bus_op_sequencer #(.ADDR_W(AW), .SNOOP_TIMEOUT(TO), .STAT_W(SW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr), .bus_grant(bus_grant),
        .snoop_valid(snoop_valid), .snoop_result(snoop_result), .wb_done(wb_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_shared(rsp_shared),
        .rsp_timeout(rsp_timeout), .protocol_err(protocol_err),
        .cnt_hitm(cnt_hitm), .cnt_timeout(cnt_timeout), .state_dbg(state_dbg)
    );

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    logic check_en = 1'b0;

    // Model expectations for the current cycle.
    logic          exp_ready, exp_bus, exp_rsp, exp_shared, exp_to, exp_perr;
    logic [2:0]    exp_op;
    logic [AW-1:0] exp_addr;
    int            exp_hitm = 0;
    int            exp_tocnt = 0;

    // Observations used by the literal checks.
    int   t_acc, rsp_cyc, bus_cycles;
    bit   rsp_seen;
    logic last_shared, last_to;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v < (1 << SW) - 1) ? v + 1 : v;
    endfunction

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (check_en) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("bus_valid", 32'(bus_valid), 32'(exp_bus));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
            chk("protocol_err", 32'(protocol_err), 32'(exp_perr));
            chk("cnt_hitm", 32'(cnt_hitm), 32'(exp_hitm));
            chk("cnt_timeout", 32'(cnt_timeout), 32'(exp_tocnt));
            if (exp_bus) begin
                chk("bus_op", 32'(bus_op), 32'(exp_op));
                chk("bus_addr", bus_addr, exp_addr);
            end
            if (exp_rsp) begin
                chk("rsp_shared", 32'(rsp_shared), 32'(exp_shared));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
            end
        end
        if (rsp_valid === 1'b1 && !rsp_seen) begin
            rsp_seen    = 1'b1;
            rsp_cyc     = cyc_n;
            last_shared = rsp_shared;
            last_to     = rsp_timeout;
        end
        if (bus_valid === 1'b1) bus_cycles++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_phase(input logic r, input logic b, input logic v);
        exp_ready = r;
        exp_bus   = b;
        exp_rsp   = v;
        exp_perr  = 1'b0;
    endtask

    // Random junk on every input; each phase then overrides the ones that matter.
    task automatic noise();
        req_valid    = 1'($urandom_range(0, 1));
        req_op       = 3'($urandom_range(0, 7));
        req_addr     = $urandom();
        bus_grant    = 1'($urandom_range(0, 1));
        snoop_valid  = 1'($urandom_range(0, 1));
        snoop_result = 2'($urandom_range(0, 3));
        wb_done      = 1'($urandom_range(0, 1));
        rsp_ready    = 1'($urandom_range(0, 1));
    endtask

    // gdel: idle ISSUE cycles before grant; sdel: SNOOP cycle carrying the result
    // (>= TO means no snoop); wdel: cycles before wb_done; rdel: cycles before rsp_ready.
    task automatic run_txn(input logic [2:0] op, input logic [AW-1:0] addr, input int gdel,
                           input int sdel, input logic [1:0] res, input int wdel, input int rdel);
        logic sh, tmo, inv_hitm, go_wb;
        rsp_seen   = 1'b0;
        bus_cycles = 0;
        t_acc      = cyc_n;
        noise();
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        set_phase(1'b1, 1'b0, 1'b0);
        step();
        if (!(op >= 3'd1 && op <= 3'd4)) begin
            noise();
            req_valid = 1'b0;
            set_phase(1'b1, 1'b0, 1'b0);
            exp_perr = 1'b1;
            step();
            return;
        end
        exp_op   = op;
        exp_addr = addr;
        for (int i = 0; i <= gdel; i++) begin
            noise();
            bus_grant = (i == gdel);
            set_phase(1'b0, 1'b1, 1'b0);
            step();
        end
        sh = 1'b0; tmo = 1'b0; inv_hitm = 1'b0; go_wb = 1'b0;
        if (op != OP_WRITE) begin
            for (int j = 0; j < TO; j++) begin
                noise();
                snoop_valid = (j == sdel);
                if (j == sdel) snoop_result = res;
                set_phase(1'b0, 1'b0, 1'b0);
                step();
                if (j == sdel) break;
            end
            if (sdel >= TO) begin
                tmo = 1'b1;
                exp_tocnt = sat(exp_tocnt);
            end else begin
                case (res)
                    2'd0: sh = 1'b0;
                    2'd2: begin
                        exp_hitm = sat(exp_hitm);
                        if (op == OP_INV) inv_hitm = 1'b1;
                        else go_wb = 1'b1;
                    end
                    default: sh = (op == OP_READ);
                endcase
            end
        end
        if (go_wb) begin
            for (int k = 0; k <= wdel; k++) begin
                noise();
                wb_done = (k == wdel);
                set_phase(1'b0, 1'b0, 1'b0);
                step();
            end
            sh = (op == OP_READ);
        end
        for (int k = 0; k <= rdel; k++) begin
            noise();
            rsp_ready = (k == rdel);
            set_phase(1'b0, 1'b0, 1'b1);
            exp_shared = sh;
            exp_to     = tmo;
            if (k == 0 && inv_hitm) exp_perr = 1'b1;
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_op = '0; req_addr = '0; bus_grant = 1'b0;
        snoop_valid = 1'b0; snoop_result = '0; wb_done = 1'b0; rsp_ready = 1'b0;
        rsp_seen = 1'b0; bus_cycles = 0; t_acc = 0; rsp_cyc = 0;
        last_shared = 1'b0; last_to = 1'b0;
        exp_op = '0; exp_addr = '0; exp_shared = 1'b0; exp_to = 1'b0;
        set_phase(1'b1, 1'b0, 1'b0);
        step();
        check_en = 1'b1;
        @(negedge clk);
        chk("rst_bus_op", 32'(bus_op), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_rsp_shared", 32'(rsp_shared), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        step();
        rst = 1'b0;

        run_txn(OP_READ, 32'h40, 0, 0, 2'd0, 0, 0);
        chk("read_nohit_lat", 32'(rsp_cyc - t_acc), 32'd3);
        chk("read_nohit_shared", 32'(last_shared), 32'd0);
        chk("read_nohit_to", 32'(last_to), 32'd0);
        run_txn(OP_READ, 32'h80, 0, 0, 2'd1, 0, 2);
        chk("read_hit_shared", 32'(last_shared), 32'd1);
        run_txn(OP_RWIM, 32'hc0, 0, 0, 2'd1, 0, 0);
        chk("rwim_hit_shared", 32'(last_shared), 32'd0);
        run_txn(OP_WRITE, 32'h100, 0, 0, 2'd2, 0, 0);
        chk("write_lat", 32'(rsp_cyc - t_acc), 32'd2);
        chk("write_shared", 32'(last_shared), 32'd0);
        run_txn(OP_READ, 32'h140, 4, 0, 2'd2, 4, 0);
        chk("hitm_bus_held", 32'(bus_cycles), 32'd5);
        chk("hitm_lat", 32'(rsp_cyc - t_acc), 32'd12);
        chk("hitm_shared", 32'(last_shared), 32'd1);
        chk("hitm_count", 32'(cnt_hitm), 32'd1);
        run_txn(OP_READ, 32'h180, 0, TO, 2'd0, 0, 0);
        chk("timeout_lat", 32'(rsp_cyc - t_acc), 32'd17);
        chk("timeout_flag", 32'(last_to), 32'd1);
        chk("timeout_count", 32'(cnt_timeout), 32'd1);
        run_txn(OP_READ, 32'h1c0, 0, 14, 2'd1, 0, 0);
        chk("late_snoop_lat", 32'(rsp_cyc - t_acc), 32'd17);
        chk("late_snoop_to", 32'(last_to), 32'd0);
        chk("late_snoop_shared", 32'(last_shared), 32'd1);
        run_txn(3'd0, 32'h200, 0, 0, 2'd0, 0, 0);
        chk("illegal_no_bus", 32'(bus_cycles), 32'd0);
        run_txn(OP_INV, 32'h240, 0, 0, 2'd2, 0, 0);
        chk("inv_hitm_shared", 32'(last_shared), 32'd0);
        chk("inv_hitm_rsp", 32'(rsp_seen), 32'd1);

        // Reset while waiting for the HITM writeback.
        noise(); req_valid = 1'b1; req_op = OP_READ; req_addr = 32'h280;
        set_phase(1'b1, 1'b0, 1'b0);
        step();
        exp_op = OP_READ; exp_addr = 32'h280;
        noise(); bus_grant = 1'b1;
        set_phase(1'b0, 1'b1, 1'b0);
        step();
        noise(); snoop_valid = 1'b1; snoop_result = 2'd2;
        set_phase(1'b0, 1'b0, 1'b0);
        step();
        exp_hitm = sat(exp_hitm);
        noise(); wb_done = 1'b0; rst = 1'b1;
        set_phase(1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        noise(); req_valid = 1'b0;
        set_phase(1'b1, 1'b0, 1'b0);
        exp_hitm = 0; exp_tocnt = 0;
        @(negedge clk);
        chk("mid_rst_bus_op", 32'(bus_op), 32'd0);
        chk("mid_rst_bus_addr", bus_addr, 32'd0);
        chk("mid_rst_shared", 32'(rsp_shared), 32'd0);
        step();

        for (int n = 0; n < 250; n++) begin
            logic [2:0] op;
            int sd;
            if ($urandom_range(0, 9) == 0) begin
                op = 3'($urandom_range(4, 7));
                if (op == 3'd4) op = 3'd0;
            end else begin
                op = 3'($urandom_range(1, 4));
            end
            sd = ($urandom_range(0, 3) == 0) ? TO + 2 : $urandom_range(0, TO - 1);
            run_txn(op, $urandom(), $urandom_range(0, 3), sd, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 3), $urandom_range(0, 2));
        end

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
